alu_rsv_module: RTL
===================

ALU_RSV_MODULE -- requirements
Module: alu_rsv_module

Interface
REQ-001 Parameter ENTRY_NUM, default 4, sets the number of reservation entries (2..8).
REQ-002 Parameter ROB_ID_WIDTH, default 8, is the ROB id width; the MSB is the wrap bit.
REQ-003 Parameter PRF_CODE_WIDTH, default 6, is the physical register code width.
REQ-004 Parameter PRF_DATA_WIDTH, default 32, is the operand width.
REQ-005 Parameter DECINFO_WIDTH, default 64, is the decode info bus width.
REQ-006 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1, is an asynchronous, active-high reset.
REQ-008 Ports i_disp_vld/o_disp_rdy, in/out, 1 each, form the dispatch handshake; an entry is enqueued when both are high.
REQ-009 Ports i_disp_src{1,2}_vld (1), i_disp_src{1,2}_rdy (1), i_disp_src{1,2}_code (PRF_CODE_WIDTH) and i_disp_src{1,2}_dat (PRF_DATA_WIDTH) are inputs giving per-operand use flag, ready flag, tag and data.
REQ-010 Ports i_disp_dst_vld (1), i_disp_dst_code, i_disp_imm (32), i_disp_rob_id, i_disp_decinfo_bus and i_disp_excp_code (8) are inputs carrying the dispatch payload.
REQ-011 Ports i_wb{0,1}_vld (1), i_wb{0,1}_code and i_wb{0,1}_dat are inputs forming two wakeup/writeback ports.
REQ-012 Port i_exu_rdy, input, 1, is high when the ALU is idle and can accept an issue.
REQ-013 Ports o_rsv_exu_vld (1) plus o_rsv_exu_src{1,2}_{vld,dat}, dst_{vld,code}, imm, rob_id, decinfo_bus and excp_code are outputs carrying the issue payload; src3 is tied to 0.
REQ-014 Ports i_csr_trap_flush (1), i_exu_mis_flush (1), i_exu_mis_rob_id, i_exu_ls_flush (1) and i_exu_ls_rob_id are the flush inputs.

Function
REQ-015 An entry is issuable when it is valid and each operand is either unused (src_vld=0) or ready.
REQ-016 o_rsv_exu_vld shall be high for exactly the cycle in which i_exu_rdy=1 and at least one entry is issuable.
REQ-017 When several entries are issuable, the oldest by ROB age shall be selected.
REQ-018 ROB age rule: A is older than B iff the MSBs are equal and low(A)<low(B), or the MSBs differ and low(A)>=low(B).
REQ-019 An issued entry shall be freed at the same clock edge at which it issues.
REQ-020 Wakeup: a valid, not-ready operand whose code equals i_wbN_code while i_wbN_vld=1 shall capture i_wbN_dat and set ready at that edge; if both ports match, wb0 wins.
REQ-021 A dispatched operand with rdy=0 that matches a wakeup port in the enqueue cycle shall be enqueued ready with the wakeup data.
REQ-022 o_disp_rdy = 1 iff at least one entry is free, evaluated on registered state; a slot freed in the current cycle is not reusable until the next cycle.
REQ-023 Enqueue shall fill the lowest-index free entry.
REQ-024 While i_csr_trap_flush=1, all entries are invalidated, enqueue is suppressed and o_rsv_exu_vld=0.
REQ-025 Mis/ls flush: the flush id is whichever of the mis and ls ids is older when both flushes are asserted, otherwise the asserted one.
REQ-026 Every entry, including one being enqueued, is invalidated when the flush id is older than its rob_id; issue is suppressed in any flush cycle.
REQ-027 Issue-payload outputs shall be combinational from the selected entry and shall be 0 when o_rsv_exu_vld=0.

Reset
REQ-028 While rst=1, all entry valid and ready bits shall clear, o_rsv_exu_vld=0 and o_disp_rdy=1 (after entry clear); entry payloads are don't-care.
REQ-029 Reset asserted mid-operation shall discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-030 With RSV_WB_BYPASS_EN defined, an entry whose last operand wakes in cycle t shall be issuable in cycle t, with the wb data forwarded onto o_rsv_exu_src*_dat.
REQ-031 Without RSV_WB_BYPASS_EN, such an entry shall become issuable no earlier than cycle t+1.

Verification
REQ-032 Dispatch 4 entries, each with both operands ready, while i_exu_rdy=0 -> o_disp_rdy=0 after the 4th; raise i_exu_rdy -> entries issue in ROB order, one per cycle.
REQ-033 Enqueue rob 0x05 with src1 code 0x12 not ready; pulse wb1 with code 0x12, dat 0xDEADBEEF -> issue occurs with src1_dat=0xDEADBEEF, at wakeup cycle +1 (macro off) or in the same cycle (macro on).
REQ-034 Entries hold rob 0x7E and 0x81; apply mis flush with id 0x7F -> 0x81 is removed and 0x7E remains and later issues.
REQ-035 Drive mis flush id 0x10 and ls flush id 0x0C together with entries 0x0D and 0x0B -> only 0x0B survives.
REQ-036 Assert trap flush in the same cycle as a dispatch -> no entry is enqueued, o_rsv_exu_vld=0, and all entries are empty on the next cycle.
REQ-037 Assert rst asynchronously while 3 entries are valid -> outputs clear before the next edge, and o_disp_rdy=1 after reset release.

Source files
------------

// File: rtl/alu_rsv_if.sv
// Dispatch, wakeup, issue and flush bundle of the ALU reservation station.
// The slave modport is the reservation station; the master side drives it.
interface alu_rsv_if #(
  parameter int ROB_ID_WIDTH   = 8,
  parameter int PRF_CODE_WIDTH = 6,
  parameter int PRF_DATA_WIDTH = 32,
  parameter int DECINFO_WIDTH  = 64
);
  logic                      i_disp_vld;
  logic                      o_disp_rdy;
  logic                      i_disp_src1_vld;
  logic                      i_disp_src1_rdy;
  logic [PRF_CODE_WIDTH-1:0] i_disp_src1_code;
  logic [PRF_DATA_WIDTH-1:0] i_disp_src1_dat;
  logic                      i_disp_src2_vld;
  logic                      i_disp_src2_rdy;
  logic [PRF_CODE_WIDTH-1:0] i_disp_src2_code;
  logic [PRF_DATA_WIDTH-1:0] i_disp_src2_dat;
  logic                      i_disp_dst_vld;
  logic [PRF_CODE_WIDTH-1:0] i_disp_dst_code;
  logic [31:0]               i_disp_imm;
  logic [ROB_ID_WIDTH-1:0]   i_disp_rob_id;
  logic [DECINFO_WIDTH-1:0]  i_disp_decinfo_bus;
  logic [7:0]                i_disp_excp_code;
  logic                      i_wb0_vld;
  logic [PRF_CODE_WIDTH-1:0] i_wb0_code;
  logic [PRF_DATA_WIDTH-1:0] i_wb0_dat;
  logic                      i_wb1_vld;
  logic [PRF_CODE_WIDTH-1:0] i_wb1_code;
  logic [PRF_DATA_WIDTH-1:0] i_wb1_dat;
  logic                      i_exu_rdy;
  logic                      o_rsv_exu_vld;
  logic                      o_rsv_exu_src1_vld;
  logic [PRF_DATA_WIDTH-1:0] o_rsv_exu_src1_dat;
  logic                      o_rsv_exu_src2_vld;
  logic [PRF_DATA_WIDTH-1:0] o_rsv_exu_src2_dat;
  logic                      o_rsv_exu_src3_vld;
  logic [PRF_DATA_WIDTH-1:0] o_rsv_exu_src3_dat;
  logic                      o_rsv_exu_dst_vld;
  logic [PRF_CODE_WIDTH-1:0] o_rsv_exu_dst_code;
  logic [31:0]               o_rsv_exu_imm;
  logic [ROB_ID_WIDTH-1:0]   o_rsv_exu_rob_id;
  logic [DECINFO_WIDTH-1:0]  o_rsv_exu_decinfo_bus;
  logic [7:0]                o_rsv_exu_excp_code;
  logic                      i_csr_trap_flush;
  logic                      i_exu_mis_flush;
  logic [ROB_ID_WIDTH-1:0]   i_exu_mis_rob_id;
  logic                      i_exu_ls_flush;
  logic [ROB_ID_WIDTH-1:0]   i_exu_ls_rob_id;

  modport slave (
    input  i_disp_vld, i_disp_src1_vld, i_disp_src1_rdy, i_disp_src1_code, i_disp_src1_dat,
           i_disp_src2_vld, i_disp_src2_rdy, i_disp_src2_code, i_disp_src2_dat,
           i_disp_dst_vld, i_disp_dst_code, i_disp_imm, i_disp_rob_id, i_disp_decinfo_bus,
           i_disp_excp_code, i_wb0_vld, i_wb0_code, i_wb0_dat, i_wb1_vld, i_wb1_code,
           i_wb1_dat, i_exu_rdy, i_csr_trap_flush, i_exu_mis_flush, i_exu_mis_rob_id,
           i_exu_ls_flush, i_exu_ls_rob_id,
    output o_disp_rdy, o_rsv_exu_vld, o_rsv_exu_src1_vld, o_rsv_exu_src1_dat,
           o_rsv_exu_src2_vld, o_rsv_exu_src2_dat, o_rsv_exu_src3_vld, o_rsv_exu_src3_dat,
           o_rsv_exu_dst_vld, o_rsv_exu_dst_code, o_rsv_exu_imm, o_rsv_exu_rob_id,
           o_rsv_exu_decinfo_bus, o_rsv_exu_excp_code
  );

  modport master (
    output i_disp_vld, i_disp_src1_vld, i_disp_src1_rdy, i_disp_src1_code, i_disp_src1_dat,
           i_disp_src2_vld, i_disp_src2_rdy, i_disp_src2_code, i_disp_src2_dat,
           i_disp_dst_vld, i_disp_dst_code, i_disp_imm, i_disp_rob_id, i_disp_decinfo_bus,
           i_disp_excp_code, i_wb0_vld, i_wb0_code, i_wb0_dat, i_wb1_vld, i_wb1_code,
           i_wb1_dat, i_exu_rdy, i_csr_trap_flush, i_exu_mis_flush, i_exu_mis_rob_id,
           i_exu_ls_flush, i_exu_ls_rob_id,
    input  o_disp_rdy, o_rsv_exu_vld, o_rsv_exu_src1_vld, o_rsv_exu_src1_dat,
           o_rsv_exu_src2_vld, o_rsv_exu_src2_dat, o_rsv_exu_src3_vld, o_rsv_exu_src3_dat,
           o_rsv_exu_dst_vld, o_rsv_exu_dst_code, o_rsv_exu_imm, o_rsv_exu_rob_id,
           o_rsv_exu_decinfo_bus, o_rsv_exu_excp_code
  );
endinterface

// File: rtl/alu_rsv_module.sv
// ALU reservation station: oldest-ready issue, two-port wakeup, trap/mis/ls flush.
// Optional macro RSV_WB_BYPASS_EN lets an entry issue in the cycle its last operand wakes.
module alu_rsv_module #(
  parameter int ENTRY_NUM      = 4,
  parameter int ROB_ID_WIDTH   = 8,
  parameter int PRF_CODE_WIDTH = 6,
  parameter int PRF_DATA_WIDTH = 32,
  parameter int DECINFO_WIDTH  = 64
) (
  input logic     clk,
  input logic     rst,
  alu_rsv_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int RW    = ROB_ID_WIDTH;

  logic [ENTRY_NUM-1:0]      ent_vld, s1_vld, s1_rdy, s2_vld, s2_rdy, dst_vld;
  logic [PRF_CODE_WIDTH-1:0] s1_code [ENTRY_NUM];
  logic [PRF_CODE_WIDTH-1:0] s2_code [ENTRY_NUM];
  logic [PRF_CODE_WIDTH-1:0] dst_code [ENTRY_NUM];
  logic [PRF_DATA_WIDTH-1:0] s1_dat [ENTRY_NUM];
  logic [PRF_DATA_WIDTH-1:0] s2_dat [ENTRY_NUM];
  logic [31:0]               imm [ENTRY_NUM];
  logic [RW-1:0]             rob_id [ENTRY_NUM];
  logic [DECINFO_WIDTH-1:0]  decinfo [ENTRY_NUM];
  logic [7:0]                excp [ENTRY_NUM];

  logic [ENTRY_NUM-1:0] w0_s1, w1_s1, w0_s2, w1_s2, s1_ok, s2_ok, issuable;
  logic [IDX_W-1:0]     sel_idx, enq_idx;
  logic                 sel_found, issue_vld, flush_any, enq_fire, enq_keep;
  logic [RW-1:0]        flush_id;
  logic                 e_w0_s1, e_w1_s1, e_w0_s2, e_w1_s2;

  // Wrap-bit age compare: true when a is older than b.
  function automatic logic rob_older(input logic [RW-1:0] a, input logic [RW-1:0] b);
    if (a[RW-1] == b[RW-1]) return a[RW-2:0] < b[RW-2:0];
    return a[RW-2:0] >= b[RW-2:0];
  endfunction

  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      w0_s1[i] = bus.i_wb0_vld && (bus.i_wb0_code == s1_code[i]);
      w1_s1[i] = bus.i_wb1_vld && (bus.i_wb1_code == s1_code[i]);
      w0_s2[i] = bus.i_wb0_vld && (bus.i_wb0_code == s2_code[i]);
      w1_s2[i] = bus.i_wb1_vld && (bus.i_wb1_code == s2_code[i]);
`ifdef RSV_WB_BYPASS_EN
      s1_ok[i] = !s1_vld[i] || s1_rdy[i] || w0_s1[i] || w1_s1[i];
      s2_ok[i] = !s2_vld[i] || s2_rdy[i] || w0_s2[i] || w1_s2[i];
`else
      s1_ok[i] = !s1_vld[i] || s1_rdy[i];
      s2_ok[i] = !s2_vld[i] || s2_rdy[i];
`endif
      issuable[i] = ent_vld[i] && s1_ok[i] && s2_ok[i];
    end
  end

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (issuable[i] && (!sel_found || rob_older(rob_id[i], rob_id[sel_idx]))) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
    enq_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!ent_vld[i]) enq_idx = IDX_W'(i);
    end
  end

  always_comb begin
    flush_any = bus.i_exu_mis_flush || bus.i_exu_ls_flush;
    if (bus.i_exu_mis_flush && bus.i_exu_ls_flush)
      flush_id = rob_older(bus.i_exu_mis_rob_id, bus.i_exu_ls_rob_id) ? bus.i_exu_mis_rob_id
                                                                      : bus.i_exu_ls_rob_id;
    else
      flush_id = bus.i_exu_mis_flush ? bus.i_exu_mis_rob_id : bus.i_exu_ls_rob_id;
  end

  assign bus.o_disp_rdy = ~&ent_vld;
  assign issue_vld      = bus.i_exu_rdy && sel_found && !bus.i_csr_trap_flush && !flush_any;
  assign enq_fire       = bus.i_disp_vld && bus.o_disp_rdy && !bus.i_csr_trap_flush;
  assign enq_keep       = !(flush_any && rob_older(flush_id, bus.i_disp_rob_id));
  assign e_w0_s1 = bus.i_wb0_vld && (bus.i_wb0_code == bus.i_disp_src1_code);
  assign e_w1_s1 = bus.i_wb1_vld && (bus.i_wb1_code == bus.i_disp_src1_code);
  assign e_w0_s2 = bus.i_wb0_vld && (bus.i_wb0_code == bus.i_disp_src2_code);
  assign e_w1_s2 = bus.i_wb1_vld && (bus.i_wb1_code == bus.i_disp_src2_code);

  always_comb begin
    bus.o_rsv_exu_vld         = issue_vld;
    bus.o_rsv_exu_src1_vld    = 1'b0;
    bus.o_rsv_exu_src1_dat    = '0;
    bus.o_rsv_exu_src2_vld    = 1'b0;
    bus.o_rsv_exu_src2_dat    = '0;
    bus.o_rsv_exu_src3_vld    = 1'b0;
    bus.o_rsv_exu_src3_dat    = '0;
    bus.o_rsv_exu_dst_vld     = 1'b0;
    bus.o_rsv_exu_dst_code    = '0;
    bus.o_rsv_exu_imm         = '0;
    bus.o_rsv_exu_rob_id      = '0;
    bus.o_rsv_exu_decinfo_bus = '0;
    bus.o_rsv_exu_excp_code   = '0;
    if (issue_vld) begin
      bus.o_rsv_exu_src1_vld    = s1_vld[sel_idx];
      bus.o_rsv_exu_src1_dat    = s1_dat[sel_idx];
      bus.o_rsv_exu_src2_vld    = s2_vld[sel_idx];
      bus.o_rsv_exu_src2_dat    = s2_dat[sel_idx];
`ifdef RSV_WB_BYPASS_EN
      // Operand waking this cycle has no stored data yet; take it straight off the wb port.
      if (s1_vld[sel_idx] && !s1_rdy[sel_idx])
        bus.o_rsv_exu_src1_dat = w0_s1[sel_idx] ? bus.i_wb0_dat : bus.i_wb1_dat;
      if (s2_vld[sel_idx] && !s2_rdy[sel_idx])
        bus.o_rsv_exu_src2_dat = w0_s2[sel_idx] ? bus.i_wb0_dat : bus.i_wb1_dat;
`endif
      bus.o_rsv_exu_dst_vld     = dst_vld[sel_idx];
      bus.o_rsv_exu_dst_code    = dst_code[sel_idx];
      bus.o_rsv_exu_imm         = imm[sel_idx];
      bus.o_rsv_exu_rob_id      = rob_id[sel_idx];
      bus.o_rsv_exu_decinfo_bus = decinfo[sel_idx];
      bus.o_rsv_exu_excp_code   = excp[sel_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld <= '0;
      s1_rdy  <= '0;
      s2_rdy  <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (bus.i_csr_trap_flush ||
            (issue_vld && (sel_idx == IDX_W'(i))) ||
            (flush_any && rob_older(flush_id, rob_id[i])))
          ent_vld[i] <= 1'b0;
        if (s1_vld[i] && (w0_s1[i] || w1_s1[i])) s1_rdy[i] <= 1'b1;
        if (s2_vld[i] && (w0_s2[i] || w1_s2[i])) s2_rdy[i] <= 1'b1;
      end
      if (enq_fire) begin
        ent_vld[enq_idx] <= enq_keep;
        s1_rdy[enq_idx]  <= bus.i_disp_src1_rdy || (bus.i_disp_src1_vld && (e_w0_s1 || e_w1_s1));
        s2_rdy[enq_idx]  <= bus.i_disp_src2_rdy || (bus.i_disp_src2_vld && (e_w0_s2 || e_w1_s2));
      end
    end
  end

  // Payload needs no reset: it is only observed through a valid entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (s1_vld[i] && !s1_rdy[i] && (w0_s1[i] || w1_s1[i]))
        s1_dat[i] <= w0_s1[i] ? bus.i_wb0_dat : bus.i_wb1_dat;
      if (s2_vld[i] && !s2_rdy[i] && (w0_s2[i] || w1_s2[i]))
        s2_dat[i] <= w0_s2[i] ? bus.i_wb0_dat : bus.i_wb1_dat;
    end
    if (enq_fire) begin
      s1_vld[enq_idx]   <= bus.i_disp_src1_vld;
      s2_vld[enq_idx]   <= bus.i_disp_src2_vld;
      s1_code[enq_idx]  <= bus.i_disp_src1_code;
      s2_code[enq_idx]  <= bus.i_disp_src2_code;
      s1_dat[enq_idx]   <= (bus.i_disp_src1_vld && !bus.i_disp_src1_rdy && e_w0_s1) ? bus.i_wb0_dat :
                           (bus.i_disp_src1_vld && !bus.i_disp_src1_rdy && e_w1_s1) ? bus.i_wb1_dat :
                           bus.i_disp_src1_dat;
      s2_dat[enq_idx]   <= (bus.i_disp_src2_vld && !bus.i_disp_src2_rdy && e_w0_s2) ? bus.i_wb0_dat :
                           (bus.i_disp_src2_vld && !bus.i_disp_src2_rdy && e_w1_s2) ? bus.i_wb1_dat :
                           bus.i_disp_src2_dat;
      dst_vld[enq_idx]  <= bus.i_disp_dst_vld;
      dst_code[enq_idx] <= bus.i_disp_dst_code;
      imm[enq_idx]      <= bus.i_disp_imm;
      rob_id[enq_idx]   <= bus.i_disp_rob_id;
      decinfo[enq_idx]  <= bus.i_disp_decinfo_bus;
      excp[enq_idx]     <= bus.i_disp_excp_code;
    end
  end
endmodule
